// File: rtl/issue_ctrl.sv
// Issue-stage sequencer: pops one instruction from the queue and holds it in front of the decoder.
// It dispatches the held instruction to the RS or the SLB and hands out a ROB tag with each dispatch.
// FENCE/SYSTEM words are held back until the ROB is empty. Undecodable words are dropped.
//
// Handshake: a queue word transfers in any cycle where iq_pop is high. iq_pop is only raised while
// iq_valid is high, and is combinational on the same cycle's inputs. The issue_rob pulse and its
// issue_rs/issue_slb companion are one-cycle strobes. issue_tag is valid in that cycle.
module issue_ctrl #(
    parameter int ROB_WIDTH = 4,
    parameter int ROB_SIZE  = 16
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 clear_in,
    input  logic                 iq_valid,
    input  logic [31:0]          iq_instr,
    input  logic [31:0]          iq_pc,
    output logic                 iq_pop,
    output logic [31:0]          dec_instr,
    output logic [31:0]          dec_npc,
    output logic                 dec_has_instr,
    input  logic                 dec_to_slb,
    input  logic [7:0]           dec_op,
    input  logic                 rs_full,
    input  logic                 slb_full,
    input  logic                 rob_full,
    input  logic                 rob_empty,
    output logic                 issue_rs,
    output logic                 issue_slb,
    output logic                 issue_rob,
    output logic [ROB_WIDTH-1:0] issue_tag,
    output logic                 illegal,
    output logic [1:0]           dbg_state     // 0 = EMPTY, 1 = HELD, 2 = DRAIN
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HELD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [31:0]          instr_q, instr_d;
    logic [31:0]          npc_q, npc_d;
    logic [ROB_WIDTH-1:0] tag_q, tag_d;
    logic                 illegal_q, illegal_d;

    logic is_invalid, is_serial, target_full, has_instr;
    logic active, fire, drop;
    logic unused_op_bits;

    assign unused_op_bits = ^dec_op[1:0];

    // Classify the held word and decide whether it dispatches or drops this cycle
    always_comb begin
        is_invalid  = (dec_op[7:5] == 3'd0);
        is_serial   = (dec_op[7:5] == 3'd2) && ((dec_op[4:2] == 3'd4) || (dec_op[4:2] == 3'd5));
        target_full = dec_to_slb ? slb_full : rs_full;
        has_instr   = (state_q != ST_EMPTY);
        // Reset, a stalled pipeline or a flush suppress every strobe
        active      = rst_in && rdy_in && !clear_in;
        fire        = active && has_instr && !is_invalid && !rob_full && !target_full
                      && (!is_serial || rob_empty);
        drop        = active && has_instr && is_invalid;
        iq_pop      = active && iq_valid && (!has_instr || fire || drop);
        issue_rob   = fire;
        issue_rs    = fire && !dec_to_slb;
        issue_slb   = fire && dec_to_slb;
    end

    // Next-state: load on pop, retire the latch on fire/drop, flush on clear
    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        npc_d     = npc_q;
        tag_d     = tag_q;
        illegal_d = illegal_q;
        if (rdy_in && clear_in) begin
            state_d = ST_EMPTY;
            tag_d   = '0;
        end else if (rdy_in) begin
            if (fire || drop) begin
                state_d = ST_EMPTY;
            end else if (has_instr && is_serial && !rob_empty) begin
                state_d = ST_DRAIN;
            end
            if (fire) begin
                tag_d = (tag_q == ROB_WIDTH'(ROB_SIZE - 1)) ? '0 : tag_q + 1'b1;
            end
            if (drop) begin
                illegal_d = 1'b1;
            end
            if (iq_pop) begin
                state_d = ST_HELD;
                instr_d = iq_instr;
                npc_d   = iq_pc;
            end
        end
    end

    // State register with asynchronous active-low reset
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q   <= ST_EMPTY;
            instr_q   <= '0;
            npc_q     <= '0;
            tag_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            npc_q     <= npc_d;
            tag_q     <= tag_d;
            illegal_q <= illegal_d;
        end
    end

    assign dec_instr     = instr_q;
    assign dec_npc       = npc_q;
    assign dec_has_instr = has_instr;
    assign issue_tag     = tag_q;
    assign illegal       = illegal_q;
    assign dbg_state     = state_q;

endmodule
